// File: rtl/intersection_scheduler.sv
// rtl/intersection_scheduler.sv - demand-actuated NS/EW/pedestrian phase scheduler
//
// Purpose: arbitrates green time between the NS and EW approaches and a
// pedestrian WALK phase. Requests are latched every clk. Phase timing
// advances only on the single-cycle tick strobe.
//
// Optional feature macro: EMERGENCY_PREEMPT_EN (adds the preempt input).
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   tick                  timing strobe; all durations count ticks
//   ns_car, ew_car        vehicle sensors (level)
//   ped_btn               pedestrian push-button
//   preempt               emergency preemption level (macro builds only)
//   ns_g/ns_y/ns_r        NS lamps, exactly one high
//   ew_g/ew_y/ew_r        EW lamps, exactly one high
//   walk                  pedestrian WALK lamp
//   ped_wait              pedestrian request latched
module intersection_scheduler #(
    parameter int MIN_GREEN    = 3,
    parameter int YELLOW_TICKS = 2,
    parameter int ALLRED_TICKS = 1,
    parameter int WALK_TICKS   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic ns_car,
    input  logic ew_car,
    input  logic ped_btn,
`ifdef EMERGENCY_PREEMPT_EN
    input  logic preempt,
`endif
    output logic ns_g,
    output logic ns_y,
    output logic ns_r,
    output logic ew_g,
    output logic ew_y,
    output logic ew_r,
    output logic walk,
    output logic ped_wait
);

    localparam int MAX_AB = (MIN_GREEN > YELLOW_TICKS) ? MIN_GREEN : YELLOW_TICKS;
    localparam int MAX_CD = (ALLRED_TICKS > WALK_TICKS) ? ALLRED_TICKS : WALK_TICKS;
    localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] GREEN_LAST  = CW'(MIN_GREEN - 1);
    localparam logic [CW-1:0] YELLOW_LAST = CW'(YELLOW_TICKS - 1);
    localparam logic [CW-1:0] ALLRED_LAST = CW'(ALLRED_TICKS - 1);
    localparam logic [CW-1:0] WALK_LAST   = CW'(WALK_TICKS - 1);

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        NS_ALLRED = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        EW_ALLRED = 3'd5,
        WALK      = 3'd6
    } state_t;

    localparam logic DIR_NS = 1'b0;
    localparam logic DIR_EW = 1'b1;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ns_pend_q, ns_pend_d;
    logic            ew_pend_q, ew_pend_d;
    logic            ped_pend_q, ped_pend_d;
    logic            next_dir_q, next_dir_d;
    logic            preempt_w;
    state_t          next_green;

`ifdef EMERGENCY_PREEMPT_EN
    assign preempt_w = preempt;
`else
    assign preempt_w = 1'b0;
`endif

    assign next_green = (next_dir_q == DIR_NS) ? NS_GREEN : EW_GREEN;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        next_dir_d = next_dir_q;

        if (tick) begin
            case (state_q)
                NS_GREEN: begin
                    if (preempt_w)
                        state_d = NS_YELLOW;
                    else if (cnt_q < GREEN_LAST)
                        cnt_d = cnt_q + 1'b1;
                    else if (ew_pend_q || ped_pend_q)
                        state_d = NS_YELLOW;
                end
                EW_GREEN: begin
                    if (preempt_w)
                        state_d = EW_YELLOW;
                    else if (cnt_q < GREEN_LAST)
                        cnt_d = cnt_q + 1'b1;
                    else if (ns_pend_q || ped_pend_q)
                        state_d = EW_YELLOW;
                end
                NS_YELLOW: begin
                    if (cnt_q == YELLOW_LAST) begin
                        state_d    = NS_ALLRED;
                        next_dir_d = DIR_EW;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                EW_YELLOW: begin
                    if (cnt_q == YELLOW_LAST) begin
                        state_d    = EW_ALLRED;
                        next_dir_d = DIR_NS;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                NS_ALLRED, EW_ALLRED: begin
                    // Preemption parks the intersection in all-red.
                    if (preempt_w)
                        cnt_d = '0;
                    else if (cnt_q == ALLRED_LAST)
                        state_d = ped_pend_q ? WALK : next_green;
                    else
                        cnt_d = cnt_q + 1'b1;
                end
                WALK: begin
                    if (preempt_w)
                        state_d = NS_ALLRED;
                    else if (cnt_q == WALK_LAST)
                        state_d = next_green;
                    else
                        cnt_d = cnt_q + 1'b1;
                end
                default: begin
                    state_d = NS_GREEN;
                end
            endcase

            if (state_d != state_q)
                cnt_d = '0;
        end

        // Latches set every clk; entering the serving state clears, and the
        // clear takes priority over a same-edge set.
        ns_pend_d  = ns_pend_q  | (ns_car  && (state_q != NS_GREEN));
        ew_pend_d  = ew_pend_q  | (ew_car  && (state_q != EW_GREEN));
        ped_pend_d = ped_pend_q | (ped_btn && (state_q != WALK));
        if (state_d == NS_GREEN && state_q != NS_GREEN) ns_pend_d  = 1'b0;
        if (state_d == EW_GREEN && state_q != EW_GREEN) ew_pend_d  = 1'b0;
        if (state_d == WALK     && state_q != WALK)     ped_pend_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= NS_GREEN;
            cnt_q      <= '0;
            ns_pend_q  <= 1'b0;
            ew_pend_q  <= 1'b0;
            ped_pend_q <= 1'b0;
            next_dir_q <= DIR_EW;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ns_pend_q  <= ns_pend_d;
            ew_pend_q  <= ew_pend_d;
            ped_pend_q <= ped_pend_d;
            next_dir_q <= next_dir_d;
        end
    end

    // Moore lamp decode from state only.
    assign ns_g     = (state_q == NS_GREEN);
    assign ns_y     = (state_q == NS_YELLOW);
    assign ns_r     = !(ns_g || ns_y);
    assign ew_g     = (state_q == EW_GREEN);
    assign ew_y     = (state_q == EW_YELLOW);
    assign ew_r     = !(ew_g || ew_y);
    assign walk     = (state_q == WALK);
    assign ped_wait = ped_pend_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
// tb/tb_intersection_scheduler.sv - directed self-checking bench for intersection_scheduler
module tb_intersection_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tick = 1'b0;
    logic ns_car = 1'b0;
    logic ew_car = 1'b0;
    logic ped_btn = 1'b0;
`ifdef EMERGENCY_PREEMPT_EN
    logic preempt = 1'b0;
`endif
    logic ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, ped_wait;

    int checks = 0;
    int errors = 0;

    // {ns_g,ns_y,ns_r, ew_g,ew_y,ew_r, walk}
    localparam logic [6:0] L_NSG  = 7'b100_001_0;
    localparam logic [6:0] L_NSY  = 7'b010_001_0;
    localparam logic [6:0] L_ALLR = 7'b001_001_0;
    localparam logic [6:0] L_EWG  = 7'b001_100_0;
    localparam logic [6:0] L_EWY  = 7'b001_010_0;
    localparam logic [6:0] L_WALK = 7'b001_001_1;

    logic [6:0] lamps;
    assign lamps = {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk};

    intersection_scheduler dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .ns_car   (ns_car),
        .ew_car   (ew_car),
        .ped_btn  (ped_btn),
`ifdef EMERGENCY_PREEMPT_EN
        .preempt  (preempt),
`endif
        .ns_g     (ns_g),
        .ns_y     (ns_y),
        .ns_r     (ns_r),
        .ew_g     (ew_g),
        .ew_y     (ew_y),
        .ew_r     (ew_r),
        .walk     (walk),
        .ped_wait (ped_wait)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; tick = 1'b0; ns_car = 1'b0; ew_car = 1'b0; ped_btn = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_tick();
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
    endtask

    task automatic tick_expect(input string name, input logic [6:0] exp);
        do_tick();
        checks++;
        if (lamps !== exp) begin
            errors++;
            $display("FAIL %s lamps=%b expected=%b", name, lamps, exp);
        end
    endtask

    task automatic pulse_ew();
        @(negedge clk); ew_car = 1'b1;
        @(negedge clk); ew_car = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (lamps !== L_NSG || ped_wait !== 1'b0) begin
            errors++;
            $display("FAIL reset lamps=%b ped_wait=%b expected=%b 0", lamps, ped_wait, L_NSG);
        end
        for (int i = 0; i < 20; i++) tick_expect("idle_rest", L_NSG);
    endtask

    task automatic test_ew_request();
        do_reset();
        pulse_ew();
        tick_expect("ew_T1", L_NSG);
        tick_expect("ew_T2", L_NSG);
        tick_expect("ew_T3", L_NSY);
        tick_expect("ew_T4", L_NSY);
        tick_expect("ew_T5", L_ALLR);
        tick_expect("ew_T6", L_EWG);
        checks++;
        if (dut.ew_pend_q !== 1'b0) begin
            errors++;
            $display("FAIL ew_pend_clear got=%b expected=0", dut.ew_pend_q);
        end
        // Back to NS: min green holds EW for 3 ticks.
        @(negedge clk); ns_car = 1'b1;
        @(negedge clk); ns_car = 1'b0;
        tick_expect("ns_T7", L_EWG);
        tick_expect("ns_T8", L_EWG);
        tick_expect("ns_T9", L_EWY);
        tick_expect("ns_T10", L_EWY);
        tick_expect("ns_T11", L_ALLR);
        tick_expect("ns_T12", L_NSG);
    endtask

    task automatic test_ped_walk();
        do_reset();
        pulse_ew();
        @(negedge clk); ped_btn = 1'b1;
        @(negedge clk); ped_btn = 1'b0;
        checks++;
        if (ped_wait !== 1'b1) begin
            errors++;
            $display("FAIL ped_wait_set got=%b expected=1", ped_wait);
        end
        tick_expect("ped_T1", L_NSG);
        tick_expect("ped_T2", L_NSG);
        tick_expect("ped_T3", L_NSY);
        tick_expect("ped_T4", L_NSY);
        tick_expect("ped_T5", L_ALLR);
        tick_expect("ped_T6_walk", L_WALK);
        checks++;
        if (ped_wait !== 1'b0) begin
            errors++;
            $display("FAIL ped_wait_clear got=%b expected=0", ped_wait);
        end
        @(negedge clk); ped_btn = 1'b1;
        @(negedge clk); ped_btn = 1'b0;
        checks++;
        if (ped_wait !== 1'b0) begin
            errors++;
            $display("FAIL ped_in_walk_ignored got=%b expected=0", ped_wait);
        end
        tick_expect("ped_T7_walk", L_WALK);
        tick_expect("ped_T8_walk", L_WALK);
        tick_expect("ped_T9_walk", L_WALK);
        tick_expect("ped_T10_ewg", L_EWG);
        for (int i = 0; i < 4; i++) tick_expect("no_second_walk", L_EWG);
    endtask

    task automatic test_reset_mid();
        // Continues from EW_GREEN with saturated min-green counter.
        @(negedge clk); ns_car = 1'b1; ped_btn = 1'b1;
        @(negedge clk); ns_car = 1'b0; ped_btn = 1'b0;
        tick_expect("mid_ewy", L_EWY);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        checks++;
        if (lamps !== L_NSG || ped_wait !== 1'b0 || dut.ns_pend_q !== 1'b0 || dut.ew_pend_q !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid lamps=%b ped=%b ns_pend=%b ew_pend=%b expected=%b 0 0 0",
                     lamps, ped_wait, dut.ns_pend_q, dut.ew_pend_q, L_NSG);
        end
        rst = 1'b0;
    endtask

    task automatic test_tick_hold();
        do_reset();
        @(negedge clk); ns_car = 1'b1; ew_car = 1'b1; ped_btn = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i % 10 == 9) begin
                checks++;
                if (lamps !== L_NSG) begin
                    errors++;
                    $display("FAIL tick_hold lamps=%b expected=%b", lamps, L_NSG);
                end
            end
        end
        checks++;
        if (ped_wait !== 1'b1 || dut.ew_pend_q !== 1'b1 || dut.ns_pend_q !== 1'b0) begin
            errors++;
            $display("FAIL hold_pends ped=%b ew=%b ns=%b expected=1 1 0",
                     ped_wait, dut.ew_pend_q, dut.ns_pend_q);
        end
        ns_car = 1'b0; ew_car = 1'b0; ped_btn = 1'b0;
    endtask

`ifdef EMERGENCY_PREEMPT_EN
    task automatic test_preempt();
        do_reset();
        pulse_ew();
        for (int i = 0; i < 5; i++) do_tick();
        tick_expect("pre_ewg", L_EWG);
        @(negedge clk); preempt = 1'b1;
        tick_expect("pre_ewy", L_EWY);
        tick_expect("pre_ewy2", L_EWY);
        tick_expect("pre_allr", L_ALLR);
        for (int i = 0; i < 3; i++) tick_expect("pre_hold", L_ALLR);
        @(negedge clk); ped_btn = 1'b1;
        @(negedge clk); ped_btn = 1'b0; preempt = 1'b0;
        tick_expect("pre_release_walk", L_WALK);
    endtask
`endif

    initial begin
        test_reset();
        test_ew_request();
        test_ped_walk();
        test_reset_mid();
        test_tick_hold();
`ifdef EMERGENCY_PREEMPT_EN
        test_preempt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
